// File: rtl/valid_ready_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : valid_ready_memory                                         |
// | Description : Single-port synchronous RAM behind a valid/ready request   |
// |               port. Each accepted request is a one-word write or read.   |
// |               Read data is registered and appears one cycle after the    |
// |               accepting edge.                                            |
// | Ports       : clk_i    - clock, all logic on posedge                     |
// |               rst_i    - synchronous reset, ACTIVE-LOW despite the name  |
// |               addr_i   - word address of the request                     |
// |               wdata_i  - write data (used when wr_rd_i=1)                |
// |               rdata_o  - registered read data                            |
// |               wr_rd_i  - 1 = write, 0 = read                             |
// |               valid_i  - request valid                                   |
// |               ready_o  - registered; 1 once out of reset, never stalls   |
// | Options     : MEM_RDATA_HOLD_EN - when defined, rdata_o holds the last   |
// |               read value through idle and write cycles; otherwise it     |
// |               returns to 0 on every edge that does not accept a read.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module valid_ready_memory #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    input  logic                  wr_rd_i,
    input  logic                  valid_i,
    output logic                  ready_o
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = DEPTH[ADDR_WIDTH:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic             r_ready;

    logic             w_accept;
    logic             w_in_range;

    // A request only counts once ready_o is already high, so a request on the
    // edge that releases reset is not taken.
    assign w_accept = valid_i && r_ready;

    // Addresses beyond DEPTH can only exist when DEPTH is not a power of two.
    generate
        if ((1 << ADDR_WIDTH) == DEPTH) begin : g_pow2_depth
            assign w_in_range = 1'b1;
        end else begin : g_partial_depth
            assign w_in_range = ({1'b0, addr_i} < c_DEPTH);
        end
    endgenerate

    // Storage: cleared in full by reset, written only on accepted in-range writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && wr_rd_i && w_in_range) begin
            r_mem[addr_i] <= wdata_i;
        end
    end

    // Handshake and read-data registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_accept && !wr_rd_i) begin
                r_rdata <= w_in_range ? r_mem[addr_i] : '0;
            end else begin
`ifdef MEM_RDATA_HOLD_EN
                r_rdata <= r_rdata;
`else
                r_rdata <= '0;
`endif
            end
        end
    end

    assign rdata_o = r_rdata;
    assign ready_o = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_valid_ready_memory                                      |
// | Description : Directed, table-driven bench for valid_ready_memory plus   |
// |               hand-written back-to-back write/read sequences.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_valid_ready_memory;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH-1:0]      rdata;
    logic                  wr_rd;
    logic                  valid;
    logic                  ready;

    int tests_run = 0;
    int tests_failed = 0;

    valid_ready_memory #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .wr_rd_i (wr_rd),
        .valid_i (valid),
        .ready_o (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             rst;
        logic             valid;
        logic             wr;
        logic [3:0]       addr;
        logic [15:0]      wdata;
        logic             exp_ready;
        logic [15:0]      exp_nohold;
        logic [15:0]      exp_hold;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic r, input logic v, input logic w,
                       input logic [3:0] a, input logic [15:0] d, input logic er,
                       input logic [15:0] e0, input logic [15:0] e1);
        vec_t t;
        t.name = n; t.rst = r; t.valid = v; t.wr = w; t.addr = a; t.wdata = d;
        t.exp_ready = er; t.exp_nohold = e0; t.exp_hold = e1;
        vecs.push_back(t);
    endtask

    task automatic check16(input string n, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check1(input string n, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, let the edge happen, sample after it.
    task automatic step(input logic r, input logic v, input logic w,
                        input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        rst = r; valid = v; wr_rd = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick(input logic [15:0] nohold, input logic [15:0] hold);
`ifdef MEM_RDATA_HOLD_EN
        return hold;
`else
        return nohold;
`endif
    endfunction

    initial begin
        rst = 1'b0; valid = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0;

        //   name               rst v  wr addr wdata     rdy nohold     hold
        add("rst_wr_ignored",   0, 1, 1, 4'd3, 16'hFFFF, 0, 16'h0000, 16'h0000);
        add("rst_hold",         0, 0, 0, 4'd0, 16'h0000, 0, 16'h0000, 16'h0000);
        add("rst_release",      1, 0, 0, 4'd0, 16'h0000, 1, 16'h0000, 16'h0000);
        add("rd3_after_rst",    1, 1, 0, 4'd3, 16'h0000, 1, 16'h0000, 16'h0000);
        add("wr3_a5a5",         1, 1, 1, 4'd3, 16'hA5A5, 1, 16'h0000, 16'h0000);
        add("rd3_a5a5",         1, 1, 0, 4'd3, 16'h0000, 1, 16'hA5A5, 16'hA5A5);
        add("idle_after_rd",    1, 0, 0, 4'd3, 16'h0000, 1, 16'h0000, 16'hA5A5);
        add("wr5_1111",         1, 1, 1, 4'd5, 16'h1111, 1, 16'h0000, 16'hA5A5);
        add("wr5_2222",         1, 1, 1, 4'd5, 16'h2222, 1, 16'h0000, 16'hA5A5);
        add("rd5_overwrite",    1, 1, 0, 4'd5, 16'h0000, 1, 16'h2222, 16'h2222);
        add("wr7_beef",         1, 1, 1, 4'd7, 16'hBEEF, 1, 16'h0000, 16'h2222);
        add("midstream_rst",    0, 1, 0, 4'd7, 16'h0000, 0, 16'h0000, 16'h0000);
        add("rd_on_release",    1, 1, 0, 4'd5, 16'h0000, 1, 16'h0000, 16'h0000);
        add("rd7_cleared",      1, 1, 0, 4'd7, 16'h0000, 1, 16'h0000, 16'h0000);
        add("rd5_cleared",      1, 1, 0, 4'd5, 16'h0000, 1, 16'h0000, 16'h0000);
        add("wr9_1234",         1, 1, 1, 4'd9, 16'h1234, 1, 16'h0000, 16'h0000);
        add("rd9_raw",          1, 1, 0, 4'd9, 16'h0000, 1, 16'h1234, 16'h1234);
        add("idle_wr_ignored",  1, 0, 1, 4'd9, 16'hFFFF, 1, 16'h0000, 16'h1234);
        add("rd9_unchanged",    1, 1, 0, 4'd9, 16'h0000, 1, 16'h1234, 16'h1234);

        // Reset-state sanity before the first edge with valid inputs.
        @(posedge clk); #1;
        check1("reset_ready", ready, 1'b0);
        check16("reset_rdata", rdata, 16'h0000);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check1({vecs[i].name, "_ready"}, ready, vecs[i].exp_ready);
            check16({vecs[i].name, "_rdata"}, rdata, pick(vecs[i].exp_nohold, vecs[i].exp_hold));
        end

        // Back-to-back writes to every address, then back-to-back reads.
        for (int a = 0; a < DEPTH; a++) begin
            logic [15:0] d;
            d = 16'(a) * 16'h0101;
            step(1'b1, 1'b1, 1'b1, 4'(a), d);
        end
        for (int a = 0; a < DEPTH; a++) begin
            logic [15:0] d;
            d = 16'(a) * 16'h0101;
            step(1'b1, 1'b1, 1'b0, 4'(a), 16'h0000);
            check16($sformatf("b2b_rd%0d", a), rdata, d);
            check1($sformatf("b2b_ready%0d", a), ready, 1'b1);
        end

        // Idle after the last read; write cycle after that.
        step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        check16("idle_after_b2b", rdata, pick(16'h0000, 16'h0F0F));
        step(1'b1, 1'b1, 1'b1, 4'd2, 16'hCAFE);
        check16("wr_after_b2b", rdata, pick(16'h0000, 16'h0F0F));
        step(1'b1, 1'b1, 1'b0, 4'd2, 16'h0000);
        check16("rd2_cafe", rdata, 16'hCAFE);
        step(1'b1, 1'b1, 1'b0, 4'd14, 16'h0000);
        check16("rd14_kept", rdata, 16'h0E0E);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
